// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: requester identity and arbiter FSM states.
package mem_arb_pkg;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } arb_state_e;

  // Instruction fetches always read a full word.
  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order record of which requester owns each granted memory transaction.
// The head names the requester that the next mem_rvalid_i belongs to.
// A pop on an empty FIFO is ignored; a push while full is accepted only
// when a pop retires the head in the same cycle.
module arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   push,
  input  owner_e push_owner,
  input  logic   pop,
  output owner_e head,
  output logic   empty,
  output logic   full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  owner_e           slot_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slot_q[rd_ptr_q];

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Owner storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) begin
      slot_q[wr_ptr_q] <= push_owner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and load/store share one
// memory port. The selected request is forwarded combinationally; an
// un-granted request locks the port to its owner until granted. Responses
// return in order and are routed using the owner FIFO.
// Build option: define MEM_ARB_RR_EN for round-robin tie-breaking; by
// default data has fixed priority over instr.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  // fetch requester
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  output logic        instr_rvalid_o,
  // load/store requester
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        data_rvalid_o,
  // shared memory port
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  input  logic        mem_rvalid_i,
  output logic        spurious_o
);

  arb_state_e state_q;
  arb_state_e state_d;
  owner_e     sel;
  owner_e     head;
  logic       sel_req;
  logic       can_issue;
  logic       mem_hs;
  logic       rsp_pop;
  logic       fifo_empty;
  logic       fifo_full;

`ifdef MEM_ARB_RR_EN
  owner_e     last_q;
`endif

  // Owner selection: a locked owner keeps the port, otherwise arbitrate.
  always_comb begin
    sel = OWN_INSTR;
    case (state_q)
      LOCK_I:  sel = OWN_INSTR;
      LOCK_D:  sel = OWN_DATA;
      default: begin
        if (instr_req_i && data_req_i) begin
`ifdef MEM_ARB_RR_EN
          sel = (last_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
`else
          sel = OWN_DATA;
`endif
        end else if (data_req_i) begin
          sel = OWN_DATA;
        end
      end
    endcase
  end

  assign sel_req   = (sel == OWN_DATA) ? data_req_i : instr_req_i;
  assign rsp_pop   = mem_rvalid_i && !fifo_empty;
  // A response retiring this cycle frees a slot for the request beside it.
  assign can_issue = !fifo_full || rsp_pop;
  assign mem_req_o = rstn && sel_req && can_issue;
  assign mem_hs    = mem_req_o && mem_gnt_i;

  assign instr_gnt_o = mem_hs && (sel == OWN_INSTR);
  assign data_gnt_o  = mem_hs && (sel == OWN_DATA);

  // Request fields of the selected owner; all zero while in reset.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rstn) begin
      if (sel == OWN_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o    = BE_FULL;
        mem_addr_o  = instr_addr_i;
      end
    end
  end

  // Lock the port to an owner whose request was presented but not granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d = (sel == OWN_DATA) ? LOCK_D : LOCK_I;
        end
      end
      LOCK_I, LOCK_D: begin
        if (mem_hs || !sel_req) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer remembers the owner of the most recent grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= OWN_INSTR;
    end else if (mem_hs) begin
      last_q <= sel;
    end
  end
`endif

  arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (mem_hs),
    .push_owner (sel),
    .pop        (mem_rvalid_i),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  // Response routing: data is broadcast, valid/err go to the head owner only.
  assign instr_rvalid_o = rsp_pop && (head == OWN_INSTR);
  assign data_rvalid_o  = rsp_pop && (head == OWN_DATA);
  assign instr_err_o    = instr_rvalid_o && mem_err_i;
  assign data_err_o     = data_rvalid_o && mem_err_i;
  assign instr_rdata_o  = rstn ? mem_rdata_i : '0;
  assign data_rdata_o   = rstn ? mem_rdata_i : '0;
  assign spurious_o     = rstn && mem_rvalid_i && fifo_empty;

endmodule
